wbrrarbiter: RTL

Four-master round-robin Wishbone (pipelined) arbiter with a bus-timeout watchdog. It sits between up to four bus masters and a single Wishbone slave bus, for example CPU fetch, CPU load/store, DMA and debug port. Grants are registered for one tenure, with fair rotation among the masters. A slave that stops acknowledging is aborted with an error to the owning master, so the bus cannot hang.

---
 rtl/wbrrarbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wbrrarbiter.sv
// Four-master round-robin arbiter for a pipelined Wishbone slave bus, with a
// watchdog that aborts a tenure when the slave stops answering.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_m_adr/dat/we/stb/cyc packed per-master request buses (master k in slice k)
//   o_m_ack/stall/err      per-master responses
//   o_adr/dat/we/stb/cyc   slave-side request, driven by the current owner
//   i_ack/stall/err        slave-side responses
//
// Bus-facing outputs are combinational from the registered grant state so the
// owner's cyc drop and slave responses pass through in the same cycle.
module wbrrarbiter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 19,
  parameter int unsigned TMOW = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [4*AW-1:0] i_m_adr,
  input  logic [4*DW-1:0] i_m_dat,
  input  logic [3:0]      i_m_we,
  input  logic [3:0]      i_m_stb,
  input  logic [3:0]      i_m_cyc,
  output logic [3:0]      o_m_ack,
  output logic [3:0]      o_m_stall,
  output logic [3:0]      o_m_err,
  output logic [AW-1:0]   o_adr,
  output logic [DW-1:0]   o_dat,
  output logic            o_we,
  output logic            o_stb,
  output logic            o_cyc,
  input  logic            i_ack,
  input  logic            i_stall,
  input  logic            i_err
);

  localparam int unsigned NM = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        owner, owner_nx;
  logic [1:0]        last, last_nx;
  logic [TMOW-1:0]   tcnt, tcnt_nx;

  logic [AW-1:0]     m_adr [NM];
  logic [DW-1:0]     m_dat [NM];

  logic              found;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic              tmo_fire;

  // Unpack the flat master buses into per-master slices.
  for (genvar k = 0; k < NM; k++) begin : g_unpack
    assign m_adr[k] = i_m_adr[k*AW +: AW];
    assign m_dat[k] = i_m_dat[k*DW +: DW];
  end

  // Grant state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      owner <= 2'd0;
      last  <= 2'd3;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      tcnt  <= tcnt_nx;
    end
  end

  // Arbitration, watchdog and response routing.
  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    last_nx   = last;
    tcnt_nx   = tcnt;
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_adr     = m_adr[owner];
    o_dat     = m_dat[owner];
    o_we      = i_m_we[owner];
    o_m_ack   = 4'b0000;
    o_m_err   = 4'b0000;
    o_m_stall = 4'b1111;
    found     = 1'b0;
    win       = last;
    idx       = last;
    tmo_fire  = 1'b0;

    case (state)
      ST_IDLE: begin
        tcnt_nx = '0;
        // Scan starting just after the previous winner; the previous winner
        // itself is visited last, which gives the round-robin fairness.
        for (int unsigned k = 1; k <= NM; k++) begin
          idx = last + 2'(k);
          if (!found && i_m_cyc[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          owner_nx = win;
          last_nx  = win;
          state_nx = ST_OWN;
        end
      end

      ST_OWN: begin
        o_cyc            = i_m_cyc[owner];
        o_stb            = o_cyc & i_m_stb[owner];
        tmo_fire         = o_cyc & ~i_ack & ~i_err & (&tcnt);
        o_m_ack[owner]   = i_ack;
        o_m_stall[owner] = i_stall;
        // A slave error coinciding with the watchdog yields one pulse.
        o_m_err[owner]   = i_err | tmo_fire;

        if (!o_cyc) begin
          state_nx = ST_IDLE;
          tcnt_nx  = '0;
        end else if (i_ack || i_err) begin
          tcnt_nx = '0;
        end else if (tmo_fire) begin
          state_nx = ST_DRAIN;
          tcnt_nx  = '0;
        end else begin
          tcnt_nx = tcnt + TMOW'(1);
        end
      end

      ST_DRAIN: begin
        // Bus is parked until the aborted owner lets go of its cycle.
        if (!i_m_cyc[owner]) begin
          state_nx = ST_IDLE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
